// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, default parameters, parity helper.
package uart_pkg;

  localparam int DEFAULT_DATA_BITS    = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 16;
  localparam int DEFAULT_PARITY_EN    = 1;
  localparam int DEFAULT_PARITY_ODD   = 0;
  localparam int DEFAULT_STOP_BITS    = 1;
  localparam int MAX_DATA_BITS        = 9;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    WAIT,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Zero-extended data does not change the XOR reduction, so one width serves all frames.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// TX FIFO read-side handshake: the engine (master) pops, the FIFO (slave) supplies data.
interface uart_tx_engine_if import uart_pkg::*; #(
  parameter int DATA_BITS = DEFAULT_DATA_BITS
);

  logic [DATA_BITS-1:0] FIFO_Data;
  logic                 FIFO_Empty;
  logic                 Pop_Data;

  modport master (
    input  FIFO_Data,
    input  FIFO_Empty,
    output Pop_Data
  );

  modport slave (
    output FIFO_Data,
    output FIFO_Empty,
    input  Pop_Data
  );

endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period down-counter shared by the UART transmitter and receiver.
module uart_baud_counter import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic tick
);

  localparam int            CW     = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Reload on request, otherwise count down and hold at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: pops bytes from the TX FIFO and serialises them onto Tx.
module uart_tx_engine import uart_pkg::*; #(
  parameter int DATA_BITS    = DEFAULT_DATA_BITS,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY_EN    = DEFAULT_PARITY_EN,
  parameter int PARITY_ODD   = DEFAULT_PARITY_ODD,
  parameter int STOP_BITS    = DEFAULT_STOP_BITS
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_engine_if.master  fifo,
  input  logic              BIST_Mode,
  output logic              Tx,
  output logic              Tx_Busy,
  output logic              Tx_Done
);

  localparam int             BCW       = $clog2(DATA_BITS + 1);
  localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

  tx_state_t            state;
  logic [DATA_BITS-1:0] shreg;
  logic [BCW-1:0]       bit_cnt;
  logic                 par_bit;
  logic                 tick;
  logic                 baud_load;

  // Start the bit timer when leaving WAIT and restart it at every bit boundary except the last.
  always_comb begin
    baud_load = 1'b0;
    case (state)
      WAIT:                 baud_load = 1'b1;
      START, DATA, PARITY:  baud_load = tick;
      STOP:                 baud_load = tick && (bit_cnt != LAST_STOP);
      default:              baud_load = 1'b0;
    endcase
  end

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .load(baud_load),
    .tick(tick)
  );

  // Frame sequencer; Tx is registered, so each transition edge loads the level of the next bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      Tx            <= 1'b1;
      fifo.Pop_Data <= 1'b0;
      Tx_Busy       <= 1'b0;
      Tx_Done       <= 1'b0;
      shreg         <= '0;
      bit_cnt       <= '0;
      par_bit       <= 1'b0;
    end else begin
      fifo.Pop_Data <= 1'b0;
      Tx_Done       <= 1'b0;
      case (state)
        IDLE: begin
          Tx <= 1'b1;
          if (!fifo.FIFO_Empty && !BIST_Mode) begin
            state         <= POP;
            fifo.Pop_Data <= 1'b1;
            Tx_Busy       <= 1'b1;
          end
        end
        POP: begin
          state <= WAIT;
        end
        WAIT: begin
          shreg   <= fifo.FIFO_Data;
          par_bit <= calc_parity(MAX_DATA_BITS'(fifo.FIFO_Data), 1'(PARITY_ODD));
          Tx      <= 1'b0;
          state   <= START;
        end
        START: begin
          if (tick) begin
            Tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                Tx    <= par_bit;
                state <= PARITY;
              end else begin
                Tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              Tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + BCW'(1);
            end
          end
        end
        PARITY: begin
          if (tick) begin
            Tx    <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (bit_cnt == LAST_STOP) begin
              bit_cnt <= '0;
              Tx_Busy <= 1'b0;
              Tx_Done <= 1'b1;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + BCW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: even-parity 16x instance plus an odd-parity, 2-stop, 4x instance.
module tb_uart_tx_engine;

  logic clk = 1'b0;
  logic rst;
  logic bist_m;
  logic bist_o;
  logic tx_m, busy_m, done_m;
  logic tx_o, busy_o, done_o;
  logic sel;
  logic obs_tx, obs_busy, obs_done, obs_pop;

  int total = 0;
  int bad   = 0;

  logic [7:0] q[$];
  logic       pop_q;

  always #5 clk = ~clk;

  uart_tx_engine_if #(.DATA_BITS(8)) fifo_m ();
  uart_tx_engine_if #(.DATA_BITS(8)) fifo_o ();

  uart_tx_engine #(
    .DATA_BITS   (8),
    .CLKS_PER_BIT(16),
    .PARITY_EN   (1),
    .PARITY_ODD  (0),
    .STOP_BITS   (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .fifo     (fifo_m),
    .BIST_Mode(bist_m),
    .Tx       (tx_m),
    .Tx_Busy  (busy_m),
    .Tx_Done  (done_m)
  );

  uart_tx_engine #(
    .DATA_BITS   (8),
    .CLKS_PER_BIT(4),
    .PARITY_EN   (1),
    .PARITY_ODD  (1),
    .STOP_BITS   (2)
  ) dut_odd (
    .clk      (clk),
    .rst      (rst),
    .fifo     (fifo_o),
    .BIST_Mode(bist_o),
    .Tx       (tx_o),
    .Tx_Busy  (busy_o),
    .Tx_Done  (done_o)
  );

  assign obs_tx   = sel ? tx_o   : tx_m;
  assign obs_busy = sel ? busy_o : busy_m;
  assign obs_done = sel ? done_o : done_m;
  assign obs_pop  = sel ? fifo_o.Pop_Data : fifo_m.Pop_Data;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Main TX FIFO: pops on a rising Pop_Data, data presented before the end of WAIT.
  initial begin
    fifo_m.FIFO_Empty = 1'b1;
    fifo_m.FIFO_Data  = '0;
    pop_q             = 1'b0;
    forever begin
      @(negedge clk);
      if (fifo_m.Pop_Data && !pop_q && q.size() > 0) fifo_m.FIFO_Data = q.pop_front();
      pop_q             = fifo_m.Pop_Data;
      fifo_m.FIFO_Empty = (q.size() == 0);
    end
  end

  // Odd-parity instance: a single constant byte, emptied once it has been popped.
  initial begin
    fifo_o.FIFO_Empty = 1'b1;
    fifo_o.FIFO_Data  = 8'h00;
    forever begin
      @(negedge clk);
      if (fifo_o.Pop_Data) fifo_o.FIFO_Empty = 1'b1;
    end
  end

  task automatic expect_frame(input logic [7:0] b, input logic pen, input logic par,
                              input int nstop, input int cpb, output int waited);
    logic exp_bits[$];
    int   match, busy_cnt, done_cnt;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
    if (pen) exp_bits.push_back(par);
    for (int i = 0; i < nstop; i++) exp_bits.push_back(1'b1);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (obs_pop !== 1'b1 && waited < 64);
    check_val("pop_seen", obs_pop, 1);
    if (obs_pop !== 1'b1) return;
    check_val("pop_busy", obs_busy, 1);
    check_val("pop_tx", obs_tx, 1);
    @(negedge clk);
    check_val("pop_pulse", obs_pop, 0);
    check_val("wait_tx", obs_tx, 1);
    busy_cnt = 0;
    done_cnt = 0;
    foreach (exp_bits[k]) begin
      match = 0;
      for (int c = 0; c < cpb; c++) begin
        @(negedge clk);
        if (obs_tx === exp_bits[k]) match++;
        if (obs_busy === 1'b1) busy_cnt++;
        if (obs_done === 1'b1) done_cnt++;
      end
      check_val($sformatf("byte%02h_bit%0d", b, k), match, cpb);
    end
    check_val("frame_busy", busy_cnt, exp_bits.size() * cpb);
    check_val("frame_done_early", done_cnt, 0);
    @(negedge clk);
    check_val("done_pulse", obs_done, 1);
    check_val("done_busy", obs_busy, 0);
    check_val("done_tx", obs_tx, 1);
  endtask

  initial begin
    int w;
    int pops;
    int dones;
    sel    = 1'b0;
    rst    = 1'b1;
    bist_m = 1'b0;
    bist_o = 1'b0;
    q.push_back(8'hA5);

    // Reset held with a non-empty FIFO
    repeat (3) begin
      @(negedge clk);
      check_val("rst_tx", tx_m, 1);
      check_val("rst_pop", fifo_m.Pop_Data, 0);
      check_val("rst_busy", busy_m, 0);
      check_val("rst_done", done_m, 0);
    end
    rst = 1'b0;

    // 8'hA5 even parity: 0,1,0,1,0,0,1,0,1,par 0,stop 1
    expect_frame(8'hA5, 1'b1, 1'b0, 1, 16, w);
    check_val("a5_first_pop", w, 1);

    // 8'hFF even parity -> parity 0
    q.push_back(8'hFF);
    expect_frame(8'hFF, 1'b1, 1'b0, 1, 16, w);

    // 8'h00 odd parity -> parity 1, two stop bits, 4 clocks per bit
    sel = 1'b1;
    fifo_o.FIFO_Empty = 1'b0;
    expect_frame(8'h00, 1'b1, 1'b1, 2, 4, w);
    sel = 1'b0;

    // Three queued bytes back to back: one IDLE cycle after Tx_Done, then POP
    q.push_back(8'h01);
    q.push_back(8'h02);
    q.push_back(8'h03);
    expect_frame(8'h01, 1'b1, 1'b1, 1, 16, w);
    expect_frame(8'h02, 1'b1, 1'b1, 1, 16, w);
    check_val("gap_2", w, 1);
    expect_frame(8'h03, 1'b1, 1'b0, 1, 16, w);
    check_val("gap_3", w, 1);
    pops  = 0;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (fifo_m.Pop_Data === 1'b1) pops++;
      if (done_m === 1'b1) dones++;
    end
    check_val("empty_nopop", pops, 0);
    check_val("done_single", dones, 0);

    // BIST raised mid-frame: frame completes, no further pops until it drops
    q.push_back(8'h3C);
    q.push_back(8'h55);
    fork
      expect_frame(8'h3C, 1'b1, 1'b0, 1, 16, w);
      begin
        repeat (60) @(negedge clk);
        bist_m = 1'b1;
      end
    join
    pops = 0;
    repeat (20) begin
      @(negedge clk);
      if (fifo_m.Pop_Data === 1'b1) pops++;
    end
    check_val("bist_nopop", pops, 0);
    check_val("bist_idle_busy", busy_m, 0);
    check_val("bist_idle_tx", tx_m, 1);
    bist_m = 1'b0;
    expect_frame(8'h55, 1'b1, 1'b0, 1, 16, w);
    check_val("bist_resume", w, 1);

    // Reset during data bit 4 of 8'hC3, then a clean frame of 8'h96
    q.push_back(8'hC3);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (fifo_m.Pop_Data !== 1'b1 && w < 64);
    check_val("c3_pop_seen", fifo_m.Pop_Data, 1);
    repeat (88) @(negedge clk);
    check_val("c3_bit4", tx_m, 0);
    check_val("c3_busy", busy_m, 1);
    rst = 1'b1;
    q.push_back(8'h96);
    @(negedge clk);
    check_val("abort_tx", tx_m, 1);
    check_val("abort_busy", busy_m, 0);
    check_val("abort_done", done_m, 0);
    @(negedge clk);
    check_val("abort_done2", done_m, 0);
    check_val("abort_pop", fifo_m.Pop_Data, 0);
    rst = 1'b0;
    expect_frame(8'h96, 1'b1, 1'b0, 1, 16, w);
    check_val("restart_pop", w, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
